// File: rtl/uart_pkg.sv
// Shared definitions for the console UART: receiver state encoding and the
// baud divisor helper used by both transmitter and receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_e;

  // Single source of the divisor so TX and RX rates cannot drift apart.
  function automatic int clks_per_bit(input int freq, input int baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// One-bit two-flop synchroniser for an asynchronous input; both stages reset
// to RST_VAL.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      meta_r <= RST_VAL;
      sync_r <= RST_VAL;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver with a one-entry valid/ready holding register and
// one-cycle frame-error and overrun pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int FREQ = 27000000,
  parameter int BAUD = 115200
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       uart_rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_err_o,
  output logic       overrun_o
);

  localparam int CLKS_PER_BIT = clks_per_bit(FREQ, BAUD);
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 4) begin : g_rate_check
    $error("uart_rx: FREQ/BAUD must be at least 4");
  end

  rx_state_e        state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       idx_r;
  logic [7:0]       shift_r;
  logic [7:0]       data_r;
  logic             valid_r;
  logic             frame_err_r;
  logic             overrun_r;
  logic             rx_s;

  sync_2ff #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clk  (clk_i),
    .rstn (rstn_i),
    .d    (uart_rx_i),
    .q    (rx_s)
  );

  // Receive FSM, bit timing, shift register and holding register.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      idx_r       <= 3'd0;
      shift_r     <= 8'h00;
      data_r      <= 8'h00;
      valid_r     <= 1'b0;
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
      // A delivery in the STOP branch below overrides this clear.
      if (valid_r && ready_i) begin
        valid_r <= 1'b0;
      end
      case (state_r)
        IDLE: begin
          if (!rx_s) begin
            state_r <= START;
            cnt_r   <= '0;
          end
        end
        START: begin
          if (cnt_r == HALF_LAST) begin
            cnt_r   <= '0;
            idx_r   <= 3'd0;
            state_r <= rx_s ? IDLE : DATA;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        DATA: begin
          if (cnt_r == BIT_LAST) begin
            cnt_r   <= '0;
            shift_r <= {rx_s, shift_r[7:1]};
            idx_r   <= idx_r + 3'd1;
            if (idx_r == 3'd7) begin
              state_r <= STOP;
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        STOP: begin
          if (cnt_r == BIT_LAST) begin
            cnt_r <= '0;
            if (rx_s) begin
              // Leave at mid-stop-bit so a back-to-back start edge is caught.
              state_r <= IDLE;
              if (!valid_r || ready_i) begin
                data_r  <= shift_r;
                valid_r <= 1'b1;
              end else begin
                overrun_r <= 1'b1;
              end
            end else begin
              frame_err_r <= 1'b1;
              state_r     <= BREAK;
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        BREAK: begin
          if (rx_s) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= '0;
        end
      endcase
    end
  end

  assign data_o      = data_r;
  assign valid_o     = valid_r;
  assign frame_err_o = frame_err_r;
  assign overrun_o   = overrun_r;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus random frames,
// compared against a byte-queue model of what the consumer should accept.
module tb_uart_rx;

  localparam int FREQ = 27000000;
  localparam int BAUD = 115200;
  localparam int CPB  = FREQ / BAUD;
  localparam int HALF = CPB / 2;
  localparam int LAT  = 2 + HALF + 9 * CPB + 1;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       rx_line = 1'b1;
  logic       ready = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       overrun;

  uart_rx #(.FREQ(FREQ), .BAUD(BAUD)) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .uart_rx_i   (rx_line),
    .data_o      (data),
    .valid_o     (valid),
    .ready_i     (ready),
    .frame_err_o (frame_err),
    .overrun_o   (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: bytes accepted by the consumer, pulse counts, valid activity.
  logic [7:0] acc_q[$];
  int err_cnt = 0, ovr_cnt = 0, vrise_cnt = 0, vhigh_cnt = 0, rise_cyc = 0;
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (valid && ready) acc_q.push_back(data);
    if (frame_err) err_cnt++;
    if (overrun) ovr_cnt++;
    if (valid) vhigh_cnt++;
    if (valid && !prev_valid) begin
      vrise_cnt++;
      rise_cyc = cyc;
    end
    prev_valid = valid;
  end

  int total = 0;
  int bad = 0;
  int acc_rd = 0;
  int fall_cyc = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic get_acc(output logic [31:0] v);
    if (acc_q.size() > acc_rd) begin
      v = {24'h0, acc_q[acc_rd]};
      acc_rd++;
    end else begin
      v = 32'hDEAD_BEEF;
    end
  endtask

  task automatic idle(input int n);
    rx_line = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one whole frame; optionally pulses ready for one cycle at index ready_at.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int ready_at);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    fall_cyc = cyc;
    for (int c = 0; c < 10 * CPB; c++) begin
      rx_line = bits[c / CPB];
      if (ready_at >= 0) begin
        if (c == ready_at) ready = 1'b1;
        else if (c == ready_at + 1) ready = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    rx_line = 1'b1;
  endtask

  task automatic drive(input logic lvl, input int n);
    rx_line = lvl;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [31:0] v;
    logic [7:0]  rb;
    int e0, o0, r0, h0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", {24'h0, data}, 32'h00);
    chk("rst_valid", {31'h0, valid}, 32'h0);
    chk("rst_ferr", {31'h0, frame_err}, 32'h0);
    chk("rst_ovr", {31'h0, overrun}, 32'h0);
    rstn = 1'b1;
    idle(5);

    // 0xA5 with ready high: one-cycle valid at the computed latency
    e0 = err_cnt; o0 = ovr_cnt; r0 = vrise_cnt; h0 = vhigh_cnt;
    send_frame(8'hA5, 1'b1, -1);
    idle(5);
    get_acc(v);
    chk("a5_data", v, 32'hA5);
    chk("a5_latency", rise_cyc - fall_cyc, LAT);
    chk("a5_vhigh", vhigh_cnt - h0, 1);
    chk("a5_ferr", err_cnt - e0, 0);
    chk("a5_ovr", ovr_cnt - o0, 0);

    // Short low glitch is ignored, then 0x3C
    e0 = err_cnt; r0 = vrise_cnt;
    drive(1'b0, 50);
    idle(2 * CPB);
    chk("glitch_valid", vrise_cnt - r0, 0);
    chk("glitch_ferr", err_cnt - e0, 0);
    send_frame(8'h3C, 1'b1, -1);
    idle(5);
    get_acc(v);
    chk("after_glitch", v, 32'h3C);

    // Stop bit low then held-low line: exactly one frame error
    e0 = err_cnt; r0 = vrise_cnt;
    send_frame(8'h3C, 1'b0, -1);
    drive(1'b0, 5 * CPB);
    idle(2 * CPB);
    chk("break_ferr", err_cnt - e0, 1);
    chk("break_valid", vrise_cnt - r0, 0);
    send_frame(8'h5A, 1'b1, -1);
    idle(5);
    get_acc(v);
    chk("after_break", v, 32'h5A);

    // Overrun: back-to-back with ready low
    ready = 1'b0;
    o0 = ovr_cnt;
    send_frame(8'h11, 1'b1, -1);
    send_frame(8'h22, 1'b1, -1);
    idle(5);
    chk("ovr_data", {24'h0, data}, 32'h11);
    chk("ovr_valid", {31'h0, valid}, 32'h1);
    chk("ovr_pulse", ovr_cnt - o0, 1);
    ready = 1'b1;
    idle(1);
    ready = 1'b0;
    idle(3);
    chk("drain_valid", {31'h0, valid}, 32'h0);
    get_acc(v);
    chk("drain_data", v, 32'h11);

    // Ready on the exact delivery edge: consume old, load new, no overrun
    o0 = ovr_cnt;
    send_frame(8'h11, 1'b1, -1);
    send_frame(8'h22, 1'b1, LAT - 1);
    idle(5);
    chk("edge_ovr", ovr_cnt - o0, 0);
    chk("edge_data", {24'h0, data}, 32'h22);
    chk("edge_valid", {31'h0, valid}, 32'h1);
    get_acc(v);
    chk("edge_old", v, 32'h11);
    ready = 1'b1;
    idle(3);
    get_acc(v);
    chk("edge_new", v, 32'h22);

    // Reset in the middle of data bit 4
    r0 = vrise_cnt;
    rb = 8'h96;
    drive(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive(rb[i], CPB);
    drive(rb[4], CPB / 2);
    rstn = 1'b0;
    drive(1'b1, 3);
    chk("mid_rst_data", {24'h0, data}, 32'h00);
    chk("mid_rst_valid", {31'h0, valid}, 32'h0);
    chk("mid_rst_pulses", {30'h0, frame_err, overrun}, 32'h0);
    rstn = 1'b1;
    idle(2 * CPB);
    chk("mid_rst_nobyte", vrise_cnt - r0, 0);
    send_frame(8'hF0, 1'b1, -1);
    idle(5);
    get_acc(v);
    chk("after_rst", v, 32'hF0);

    // Random bytes with random idle gaps, ready held high
    for (int i = 0; i < 4; i++) begin
      rb = 8'($urandom_range(0, 255));
      exp_q.push_back(rb);
      send_frame(rb, 1'b1, -1);
      idle($urandom_range(0, 3));
    end
    idle(5);
    while (exp_q.size() > 0) begin
      get_acc(v);
      chk("rand_byte", v, {24'h0, exp_q.pop_front()});
    end
    chk("no_extra", acc_q.size() - acc_rd, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
